// File: rtl/cpu_types_pkg.sv
// cpu_types_pkg: shared RAM handshake, word and arbiter state types
package cpu_types_pkg;
  typedef enum logic [1:0] {FREE, BUSY, ACCESS, ERROR} ramstate_t;
  typedef logic [31:0] word_t;
  typedef enum logic [1:0] {IDLE, IGNT, DGNT} arb_state_t;
endpackage

// File: rtl/arb_starve_counter.sv
// arb_starve_counter: saturating count of data completions while instruction waits
module arb_starve_counter #(
  parameter int STARVE_MAX = 4
) (
  input  logic CLK,
  input  logic nRST,
  input  logic inc,
  input  logic clr,
  output logic sat
);
  localparam int W = $clog2(STARVE_MAX + 1);
  logic [W-1:0] cnt;
  // clear wins over increment; increment stops at STARVE_MAX
  always_ff @(posedge CLK or negedge nRST)
    if (!nRST) cnt <= '0;
    else if (clr) cnt <= '0;
    else if (inc && !sat) cnt <= cnt + 1'b1;
  assign sat = cnt == W'(STARVE_MAX);
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one RAM port between icache and dcache, data first with starvation guard
module mem_arbiter
  import cpu_types_pkg::*;
#(
  parameter int STARVE_MAX = 4,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              iREN,
  input  logic [ADDR_W-1:0] iaddr,
  output logic              iwait,
  output logic [DATA_W-1:0] iload,
  input  logic              dREN,
  input  logic              dWEN,
  input  logic [ADDR_W-1:0] daddr,
  input  logic [DATA_W-1:0] dstore,
  output logic              dwait,
  output logic [DATA_W-1:0] dload,
  output logic              ramREN,
  output logic              ramWEN,
  output logic [ADDR_W-1:0] ramaddr,
  output logic [DATA_W-1:0] ramstore,
  input  logic [DATA_W-1:0] ramload,
  input  ramstate_t         ramstate,
  output logic              mem_err
);
  arb_state_t state, next_state;
  logic dreq, acc, inc, clr, sat;
  assign dreq = dREN | dWEN;
  assign acc = ramstate == ACCESS;
  assign iload = ramload;
  assign dload = ramload;
  arb_starve_counter #(.STARVE_MAX(STARVE_MAX)) u_starve (
    .CLK(CLK), .nRST(nRST), .inc(inc), .clr(clr), .sat(sat)
  );
  // grant register
  always_ff @(posedge CLK or negedge nRST)
    if (!nRST) state <= IDLE;
    else state <= next_state;
  // sticky error: RAM reported ERROR on a live granted request
  always_ff @(posedge CLK or negedge nRST)
    if (!nRST) mem_err <= 1'b0;
    else if (((state == IGNT && iREN) || (state == DGNT && dreq)) && ramstate == ERROR) mem_err <= 1'b1;
  // arbitration, RAM drive and stall release; enables depend only on state and requests
  always_comb begin
    next_state = state;
    ramREN = 1'b0;
    ramWEN = 1'b0;
    ramaddr = '0;
    ramstore = '0;
    iwait = 1'b1;
    dwait = 1'b1;
    inc = 1'b0;
    clr = 1'b0;
    case (state)
      IDLE: next_state = (dreq && !(iREN && sat)) ? DGNT : iREN ? IGNT : IDLE;
      IGNT: begin
        ramREN = iREN;
        ramaddr = iaddr;
        iwait = !(iREN && acc);
        clr = iREN && acc;
        next_state = (!iREN || acc) ? IDLE : IGNT;
      end
      DGNT: begin
        ramWEN = dWEN;
        ramREN = dREN & !dWEN;
        ramaddr = daddr;
        ramstore = dstore;
        dwait = !(dreq && acc);
        inc = dreq && acc && iREN;
        clr = dreq && acc && !iREN;
        next_state = (!dreq || acc) ? IDLE : DGNT;
      end
      default: next_state = IDLE;
    endcase
  end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: randomized and directed checks of mem_arbiter against a transaction-level model
module tb_mem_arbiter;
  import cpu_types_pkg::*;
  localparam int SM = 4;
  logic CLK = 1'b0, nRST = 1'b0;
  logic iREN = 0, dREN = 0, dWEN = 0;
  logic [31:0] iaddr = 0, daddr = 0, dstore = 0, ramload = 0;
  ramstate_t ramstate = FREE;
  logic iwait, dwait, ramREN, ramWEN, mem_err;
  logic [31:0] iload, dload, ramaddr, ramstore;
  int vectors = 0, errors = 0;
  int owner = 0;
  int starve = 0;
  bit err = 0;
  bit rec = 0;
  int ncomp = 0;
  logic [9:0] order = '0;

  mem_arbiter #(.STARVE_MAX(SM), .ADDR_W(32), .DATA_W(32)) dut (
    .CLK(CLK), .nRST(nRST), .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore), .dwait(dwait), .dload(dload),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ramstate(ramstate), .mem_err(mem_err)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // owner: 0 = nobody holds the RAM, 1 = icache transaction open, 2 = dcache transaction open
  task automatic model_edge();
    bit dr;
    dr = dREN || dWEN;
    if (!nRST) begin
      owner = 0; starve = 0; err = 0;
    end else if (owner == 0) begin
      if (dr && !(iREN && starve == SM)) owner = 2;
      else if (iREN) owner = 1;
    end else begin
      bit live;
      live = (owner == 1) ? iREN : dr;
      if (live && ramstate == ERROR) err = 1;
      if (live && ramstate == ACCESS) begin
        if (owner == 1 || !iREN) starve = 0;
        else if (starve < SM) starve = starve + 1;
      end
      if (!live || ramstate == ACCESS) owner = 0;
    end
  endtask

  task automatic check_outputs();
    bit done;
    done = ramstate == ACCESS;
    check("ramREN", ramREN, owner == 1 ? iREN : owner == 2 ? (dREN && !dWEN) : 0);
    check("ramWEN", ramWEN, owner == 2 ? dWEN : 0);
    check("ramaddr", ramaddr, owner == 1 ? iaddr : owner == 2 ? daddr : 0);
    check("ramstore", ramstore, owner == 2 ? dstore : 0);
    check("iwait", iwait, !(owner == 1 && iREN && done));
    check("dwait", dwait, !(owner == 2 && (dREN || dWEN) && done));
    check("iload", iload, ramload);
    check("dload", dload, ramload);
    check("mem_err", mem_err, err);
  endtask

  task automatic cyc(input logic ir, input logic [31:0] ia, input logic dr, input logic dw,
                     input logic [31:0] da, input logic [31:0] ds, input ramstate_t r, input logic [31:0] rl);
    @(posedge CLK);
    model_edge();
    #1;
    iREN = ir; iaddr = ia; dREN = dr; dWEN = dw; daddr = da; dstore = ds; ramstate = r; ramload = rl;
    #4;
    check_outputs();
    if (rec && ncomp < 10 && (!iwait || !dwait)) begin
      order = {order[8:0], !dwait};
      ncomp++;
    end
  endtask

  initial begin
    #2;
    check_outputs();
    check("rst_iwait", iwait, 1);
    check("rst_dwait", dwait, 1);
    #10 nRST = 1'b1;
    // single instruction fetch with a zero-wait RAM
    cyc(1, 32'h40, 0, 0, 0, 0, FREE, 0);
    cyc(1, 32'h40, 0, 0, 0, 0, ACCESS, 32'h2108000A);
    check("t1_ramREN", ramREN, 1);
    check("t1_ramaddr", ramaddr, 32'h40);
    check("t1_iwait", iwait, 0);
    check("t1_iload", iload, 32'h2108000A);
    cyc(0, 0, 0, 0, 0, 0, FREE, 0);
    check("t1_idle", ramREN, 0);
    // sustained contention: four data grants then one forced instruction grant
    rec = 1;
    for (int i = 0; i < 20; i++) cyc(1, 32'h80, 1, 0, 32'h200, 0, ACCESS, i);
    rec = 0;
    check("starve_order", order, 10'b1111011110);
    check("starve_count", ncomp, 10);
    cyc(0, 0, 0, 0, 0, 0, FREE, 0);
    // write held through three BUSY cycles
    cyc(0, 0, 0, 1, 32'h100, 32'hDEADBEEF, FREE, 0);
    for (int i = 0; i < 3; i++) begin
      cyc(0, 0, 0, 1, 32'h100, 32'hDEADBEEF, BUSY, 0);
      check("wr_busy_dwait", dwait, 1);
      check("wr_busy_ramstore", ramstore, 32'hDEADBEEF);
    end
    cyc(0, 0, 0, 1, 32'h100, 32'hDEADBEEF, ACCESS, 0);
    check("wr_acc_ramWEN", ramWEN, 1);
    check("wr_acc_dwait", dwait, 0);
    check("wr_acc_iwait", iwait, 1);
    cyc(0, 0, 0, 0, 0, 0, FREE, 0);
    // read and write together: write wins
    cyc(0, 0, 1, 1, 32'h104, 32'h5A5A, FREE, 0);
    cyc(0, 0, 1, 1, 32'h104, 32'h5A5A, ACCESS, 0);
    check("rw_ramWEN", ramWEN, 1);
    check("rw_ramREN", ramREN, 0);
    cyc(0, 0, 0, 0, 0, 0, FREE, 0);
    // ERROR retried until ACCESS; error flag is sticky
    cyc(0, 0, 1, 0, 32'h108, 0, FREE, 0);
    cyc(0, 0, 1, 0, 32'h108, 0, ERROR, 0);
    cyc(0, 0, 1, 0, 32'h108, 0, ERROR, 0);
    check("err_dwait", dwait, 1);
    cyc(0, 0, 1, 0, 32'h108, 0, ACCESS, 32'h77);
    check("err_set", mem_err, 1);
    check("err_acc_dwait", dwait, 0);
    cyc(0, 0, 0, 0, 0, 0, FREE, 0);
    check("err_sticky", mem_err, 1);
    // asynchronous reset in the middle of a data grant
    cyc(0, 0, 1, 0, 32'h10C, 0, FREE, 0);
    cyc(0, 0, 1, 0, 32'h10C, 0, BUSY, 0);
    #2 nRST = 1'b0;
    #1;
    owner = 0; starve = 0; err = 0;
    check_outputs();
    check("arst_ramREN", ramREN, 0);
    check("arst_mem_err", mem_err, 0);
    cyc(0, 0, 1, 0, 32'h10C, 0, BUSY, 0);
    #2 nRST = 1'b1;
    cyc(0, 0, 1, 0, 32'h10C, 0, ACCESS, 32'h99);
    check("arst_fresh", ramREN, 1);
    cyc(0, 0, 0, 0, 0, 0, FREE, 0);
    // random traffic against the model
    for (int i = 0; i < 600; i++) begin
      int k;
      ramstate_t r;
      k = $urandom_range(0, 9);
      r = k < 4 ? ACCESS : k < 6 ? BUSY : k < 8 ? FREE : ERROR;
      cyc($urandom_range(0, 9) < 6, $urandom, $urandom_range(0, 9) < 4, $urandom_range(0, 9) < 2,
          $urandom, $urandom, r, $urandom);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single RAM port between the instruction cache (read-only) and the data cache (read/write).
- Sits between icache/dcache and the RAM model, on the cache side of the caches_if boundary.
- Registered-grant FSM. Data has priority over instruction. A starvation counter guarantees instruction fetch progress under sustained data traffic.
- Grant is held (locked) until the RAM completes the granted transaction.

Parameters:
- STARVE_MAX, 4, consecutive completed data grants allowed while iREN stays pending before instruction is forced next (>=1)
- ADDR_W, 32, address width
- DATA_W, 32, word width

Ports:
- CLK  in  1  clock, rising edge
- nRST  in  1  reset, asynchronous, active-low
- iREN  in  1  icache read request
- iaddr  in  ADDR_W  icache word address
- iwait  out  1  icache stall; low for exactly the cycle iload is valid
- iload  out  DATA_W  instruction word returned
- dREN  in  1  dcache read request
- dWEN  in  1  dcache write request
- daddr  in  ADDR_W  dcache address
- dstore  in  DATA_W  dcache write data
- dwait  out  1  dcache stall; low for the completion cycle
- dload  out  DATA_W  data word returned
- ramREN  out  1  RAM read enable
- ramWEN  out  1  RAM write enable
- ramaddr  out  ADDR_W  RAM address
- ramstore  out  DATA_W  RAM write data
- ramload  in  DATA_W  RAM read data
- ramstate  in  2  ramstate_t: FREE, BUSY, ACCESS, ERROR
- mem_err  out  1  sticky flag, set on ERROR while granted; cleared only by reset

Behaviour:
- Reset (nRST low, async):
  - state=IDLE, starve_cnt=0, mem_err=0.
  - Outputs: iwait=1, dwait=1, ramREN=0, ramWEN=0, ramaddr=0, ramstore=0.
- Data paths: iload=ramload and dload=ramload, both combinational and always driven; valid only when the matching wait is low.
- States: IDLE, IGNT, DGNT.
- IDLE:
  - RAM enables 0, both waits 1.
  - Next state:
    - DGNT if (dREN|dWEN) and not (iREN and starve_cnt==STARVE_MAX).
    - Else IGNT if iREN.
    - Else stay in IDLE.
- IGNT:
  - ramREN=1, ramWEN=0, ramaddr=iaddr.
  - iwait = !(ramstate==ACCESS); dwait=1.
  - On ACCESS, go to IDLE next cycle and clear starve_cnt.
- DGNT:
  - ramWEN=dWEN, ramREN=dREN&!dWEN (write wins if both asserted), ramaddr=daddr, ramstore=dstore.
  - dwait = !(ramstate==ACCESS); iwait=1.
  - On ACCESS, go to IDLE and update starve_cnt: if iREN, starve_cnt = min(starve_cnt+1, STARVE_MAX); else starve_cnt=0.
- Request withdrawn while granted (requester drops REN/WEN before ACCESS):
  - Go to IDLE next cycle; RAM enables follow the request low that same cycle.
  - No wait is released; starve_cnt unchanged.
- ERROR while granted:
  - Set mem_err; wait stays 1; grant held; retry continues until ACCESS or the request is withdrawn.
- FREE/BUSY while granted: hold grant, wait=1.
- Latency:
  - Request seen in IDLE at cycle t; RAM enables asserted from t+1.
  - With a zero-wait RAM, ACCESS arrives at t+1, wait is low at t+1, and the FSM is back in IDLE at t+2.
  - Maximum throughput is one transaction per 2 cycles.
- Grant decision uses only registered state plus the current requests. No combinational path from ramstate to ramREN/ramWEN.
- Simultaneous iREN and dREN in IDLE with starve_cnt<STARVE_MAX: data is granted.
- starve_cnt width is $clog2(STARVE_MAX+1) and saturates at STARVE_MAX.

Decomposition:
- ramstate_t, word_t and the arbiter state enum (IDLE, IGNT, DGNT) go in cpu_types_pkg.
- The starvation counter is a natural sub-module, arb_starve_counter (inc/clear/saturate, parameterised by STARVE_MAX). Everything else stays flat.

Test Plan:
- Reset, then iREN=1, iaddr=0x40, RAM returns ACCESS one cycle after enable with ramload=0x2108000A -> ramREN=1 and ramaddr=0x40 from cycle 1; iwait=0 and iload=0x2108000A on the ACCESS cycle; IDLE next cycle.
- iREN=1 and dREN=1 held continuously, STARVE_MAX=4 -> grant order D,D,D,D,I,D,D,D,D,I; starve_cnt returns to 0 after each I completion.
- dWEN=1, daddr=0x100, dstore=0xDEADBEEF, RAM BUSY for 3 cycles then ACCESS -> ramWEN=1, ramstore=0xDEADBEEF held for 4 cycles; dwait=0 only on the ACCESS cycle; iwait=1 throughout.
- dREN=1 and dWEN=1 together -> ramWEN=1, ramREN=0.
- ramstate=ERROR for 2 cycles during DGNT, then ACCESS -> mem_err=1 and stays 1; grant retained; dwait low only on ACCESS.
- Assert nRST=0 mid-DGNT while ramstate=BUSY -> same-cycle async return: ramREN=ramWEN=0, iwait=dwait=1, mem_err=0, starve_cnt=0; the first request after release is arbitrated fresh.
